// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two issuers, the ALU arbiter and its consumer
interface alu_arbiter_if #(
    parameter int TAG_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [31:0]      req0_a;
    logic [31:0]      req0_b;
    logic [2:0]       req0_op;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [31:0]      req1_a;
    logic [31:0]      req1_b;
    logic [2:0]       req1_op;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_y;
    logic             rsp_zero;
    logic             rsp_ovf;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_op, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_y, rsp_zero, rsp_ovf
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_tag,
        output req1_valid, req1_a, req1_b, req1_op, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_y, rsp_zero, rsp_ovf
    );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter sharing one ALU with a registered result stage (option macro: ALU_ARB_RR_EN)
module alu_arbiter_alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [2:0]  op_i,
    output logic [31:0] y_o,
    output logic        ovf_o
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;

    // Decode the op code; overflow is only defined for add and sub
    always_comb begin
        y_o   = 32'd0;
        ovf_o = 1'b0;
        case (op_i)
            3'b010: begin
                y_o   = sum;
                ovf_o = (a_i[31] == b_i[31]) && (sum[31] != a_i[31]);
            end
            3'b110: begin
                y_o   = diff;
                ovf_o = (a_i[31] != b_i[31]) && (diff[31] != a_i[31]);
            end
            3'b000:  y_o = a_i & b_i;
            3'b001:  y_o = a_i | b_i;
            3'b100:  y_o = a_i & ~b_i;
            3'b101:  y_o = a_i | ~b_i;
            3'b111:  y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            default: y_o = 32'd0;
        endcase
    end
endmodule

module alu_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   bus
);
    logic             stage_free;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic [31:0]      a_mux;
    logic [31:0]      b_mux;
    logic [2:0]       op_mux;
    logic [TAG_W-1:0] tag_mux;
    logic [31:0]      alu_y;
    logic             alu_ovf;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q,   rsp_tag_d;
    logic [31:0]      rsp_y_q,     rsp_y_d;
    logic             rsp_zero_q,  rsp_zero_d;
    logic             rsp_ovf_q,   rsp_ovf_d;
`ifdef ALU_ARB_RR_EN
    logic             last_q,      last_d;
`endif

    // A new op may enter whenever the result register is empty or being drained
    assign stage_free = !rsp_valid_q || bus.rsp_ready;

    // Grant selection: single requester wins outright, ties go by round-robin or port 0
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && stage_free) begin
            if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
                grant0 = last_q;
                grant1 = !last_q;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign accept         = grant0 || grant1;
    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    assign a_mux   = grant1 ? bus.req1_a   : bus.req0_a;
    assign b_mux   = grant1 ? bus.req1_b   : bus.req0_b;
    assign op_mux  = grant1 ? bus.req1_op  : bus.req0_op;
    assign tag_mux = grant1 ? bus.req1_tag : bus.req0_tag;

    alu_arbiter_alu u_alu (
        .a_i   (a_mux),
        .b_i   (b_mux),
        .op_i  (op_mux),
        .y_o   (alu_y),
        .ovf_o (alu_ovf)
    );

    // Next-state for the result stage: load on accept, drop valid on a plain drain, else hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_ovf_d   = rsp_ovf_q;
`ifdef ALU_ARB_RR_EN
        last_d      = last_q;
`endif
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant1;
            rsp_tag_d   = tag_mux;
            rsp_y_d     = alu_y;
            rsp_zero_d  = (alu_y == 32'd0);
            rsp_ovf_d   = alu_ovf;
`ifdef ALU_ARB_RR_EN
            last_d      = grant1;
`endif
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Result register; reset discards any pending result and favours port 0 on the next tie
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_y_q     <= 32'd0;
            rsp_zero_q  <= 1'b1;
            rsp_ovf_q   <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q      <= 1'b1;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_ovf_q   <= rsp_ovf_d;
`ifdef ALU_ARB_RR_EN
            last_q      <= last_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_y     = rsp_y_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural model and random soak
module tb_alu_arbiter;
    logic clk;
    logic rst;
    logic soak_on;
    int   total;
    int   bad;

    alu_arbiter_if #(.TAG_W(4)) bus ();

    alu_arbiter #(.TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    // model state: content of the result register as the rules say it must be
    logic        m_valid;
    logic        m_id;
    logic [3:0]  m_tag;
    logic [31:0] m_y;
    logic        m_zero;
    logic        m_ovf;
`ifdef ALU_ARB_RR_EN
    int          m_last;
    int          waits [2];
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] y, output logic ovf);
        longint sa;
        longint sb;
        longint r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        y   = 32'd0;
        ovf = 1'b0;
        case (op)
            3'b010: begin r = sa + sb; y = r[31:0]; ovf = (r > MAXI) || (r < MINI); end
            3'b110: begin r = sa - sb; y = r[31:0]; ovf = (r > MAXI) || (r < MINI); end
            3'b000: y = a & b;
            3'b001: y = a | b;
            3'b100: y = a & ~b;
            3'b101: y = a | ~b;
            3'b111: y = (sa < sb) ? 32'd1 : 32'd0;
            default: y = 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 1'b0;
        m_tag   = 4'd0;
        m_y     = 32'd0;
        m_zero  = 1'b1;
        m_ovf   = 1'b0;
`ifdef ALU_ARB_RR_EN
        m_last   = 1;
        waits[0] = 0;
        waits[1] = 0;
`endif
    endtask

    // compare process: every cycle check readies and outputs, then advance the model over the coming edge
    initial begin
        logic e0, e1, free;
        logic [31:0] y;
        logic ovf;
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            e0   = 1'b0;
            e1   = 1'b0;
            free = !m_valid || bus.rsp_ready;
            if (!rst && free) begin
                if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
                    if (m_last == 0) e1 = 1'b1; else e0 = 1'b1;
`else
                    e0 = 1'b1;
`endif
                end else if (bus.req0_valid) e0 = 1'b1;
                else if (bus.req1_valid) e1 = 1'b1;
            end
            chk("m_ready0", bus.req0_ready, e0);
            chk("m_ready1", bus.req1_ready, e1);
            chk("m_rsp_valid", bus.rsp_valid, m_valid);
            chk("m_rsp_id", bus.rsp_id, m_id);
            chk("m_rsp_tag", bus.rsp_tag, m_tag);
            chk("m_rsp_y", bus.rsp_y, m_y);
            chk("m_rsp_zero", bus.rsp_zero, m_zero);
            chk("m_rsp_ovf", bus.rsp_ovf, m_ovf);
            if (rst) begin
                model_reset();
            end else if (e0 || e1) begin
                if (e1) ref_alu(bus.req1_op, bus.req1_a, bus.req1_b, y, ovf);
                else    ref_alu(bus.req0_op, bus.req0_a, bus.req0_b, y, ovf);
                m_valid = 1'b1;
                m_id    = e1;
                m_tag   = e1 ? bus.req1_tag : bus.req0_tag;
                m_y     = y;
                m_zero  = (y == 32'd0);
                m_ovf   = ovf;
`ifdef ALU_ARB_RR_EN
                m_last = e1 ? 1 : 0;
                waits[m_last] = 0;
                if ((m_last == 0 && bus.req1_valid) || (m_last == 1 && bus.req0_valid)) begin
                    waits[1 - m_last]++;
                    chk("starve", (waits[1 - m_last] <= 1) ? 32'd1 : 32'd0, 32'd1);
                end
`endif
            end else if (m_valid && bus.rsp_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // random driver: a requester keeps its op until accepted, then may present a new one
    initial begin
        logic acc0, acc1;
        forever begin
            @(negedge clk);
            acc0 = bus.req0_valid && bus.req0_ready;
            acc1 = bus.req1_valid && bus.req1_ready;
            @(posedge clk);
            #1;
            if (soak_on) begin
                if (!bus.req0_valid || acc0) begin
                    bus.req0_valid = ($urandom_range(0, 3) != 0);
                    bus.req0_op    = 3'($urandom_range(0, 7));
                    bus.req0_a     = pick();
                    bus.req0_b     = pick();
                    bus.req0_tag   = 4'($urandom_range(0, 15));
                end
                if (!bus.req1_valid || acc1) begin
                    bus.req1_valid = ($urandom_range(0, 3) != 0);
                    bus.req1_op    = 3'($urandom_range(0, 7));
                    bus.req1_a     = pick();
                    bus.req1_b     = pick();
                    bus.req1_tag   = 4'($urandom_range(0, 15));
                end
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
                rst           = ($urandom_range(0, 499) == 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bus.req0_valid = v;
        bus.req0_op    = op;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_tag   = tag;
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eovf, input logic ezero);
        tick();
        set0(1'b1, op, a, b, 4'd1);
        bus.rsp_ready = 1'b1;
        look();
        chk({name, "_ready"}, bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        look();
        chk({name, "_y"}, bus.rsp_y, ey);
        chk({name, "_ovf"}, bus.rsp_ovf, eovf);
        chk({name, "_zero"}, bus.rsp_zero, ezero);
    endtask

    initial begin
        int g;
        int exp_id;
        logic [3:0] tag0, tag1, exp_tag;
        total   = 0;
        bad     = 0;
        soak_on = 1'b0;
        rst     = 1'b1;
        set0(1'b0, 3'b010, 32'd0, 32'd0, 4'd0);
        bus.req1_valid = 1'b0;
        bus.req1_op    = 3'b001;
        bus.req1_a     = 32'd0;
        bus.req1_b     = 32'd0;
        bus.req1_tag   = 4'd0;
        bus.rsp_ready  = 1'b0;

        // reset state
        tick();
        tick();
        look();
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_zero", bus.rsp_zero, 1'b1);
        chk("rst_y", bus.rsp_y, 32'd0);

        // single op after reset
        tick();
        rst = 1'b0;
        set0(1'b1, 3'b010, 32'd5, 32'd7, 4'd3);
        bus.rsp_ready = 1'b1;
        look();
        chk("single_ready0", bus.req0_ready, 1'b1);
        tick();
        bus.req0_valid = 1'b0;
        look();
        chk("single_valid", bus.rsp_valid, 1'b1);
        chk("single_y", bus.rsp_y, 32'd12);
        chk("single_id", bus.rsp_id, 1'b0);
        chk("single_tag", bus.rsp_tag, 4'd3);
        chk("single_zero", bus.rsp_zero, 1'b0);

        // tie sequence from a fresh reset
        tick();
        rst = 1'b1;
        look();
        tick();
        rst  = 1'b0;
        tag0 = 4'd0;
        tag1 = 4'd8;
        set0(1'b1, 3'b010, 32'd5, 32'd7, tag0);
        bus.req1_valid = 1'b1;
        bus.req1_op    = 3'b001;
        bus.req1_a     = 32'h0000_00F0;
        bus.req1_b     = 32'h0000_000F;
        bus.req1_tag   = tag1;
        exp_id  = 0;
        exp_tag = 4'd0;
        for (int i = 0; i < 4; i++) begin
            look();
`ifdef ALU_ARB_RR_EN
            g = i % 2;
`else
            g = 0;
`endif
            chk("tie_ready0", bus.req0_ready, (g == 0));
            chk("tie_ready1", bus.req1_ready, (g == 1));
            tick();
            exp_id = g;
            if (g == 0) begin exp_tag = tag0; tag0++; bus.req0_tag = tag0; end
            else        begin exp_tag = tag1; tag1++; bus.req1_tag = tag1; end
        end

        // back-pressure: result held, nothing accepted
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("bp_ready0", bus.req0_ready, 1'b0);
            chk("bp_ready1", bus.req1_ready, 1'b0);
            chk("bp_valid", bus.rsp_valid, 1'b1);
            chk("bp_id", bus.rsp_id, exp_id);
            chk("bp_tag", bus.rsp_tag, exp_tag);
            chk("bp_y", bus.rsp_y, (exp_id == 1) ? 32'hFF : 32'd12);
            tick();
        end
        bus.rsp_ready = 1'b1;
        look();
        chk("bp_release_ready0", bus.req0_ready, 1'b1);
        chk("bp_release_ready1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        look();
        chk("bp_new_valid", bus.rsp_valid, 1'b1);
        chk("bp_new_id", bus.rsp_id, 1'b0);
        chk("bp_new_tag", bus.rsp_tag, tag0);
        chk("bp_new_y", bus.rsp_y, 32'd12);

        // flags and boundary ops
        do_op("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1, 1'b0);
        do_op("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        do_op("slt_neg", 3'b111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
        do_op("sub_zero", 3'b110, 32'd9, 32'd9, 32'd0, 1'b0, 1'b1);
        do_op("op_undef", 3'b011, 32'd5, 32'd3, 32'd0, 1'b0, 1'b1);

        // reset while a result is pending
        tick();
        set0(1'b1, 3'b010, 32'd1, 32'd1, 4'd7);
        bus.rsp_ready = 1'b0;
        look();
        tick();
        bus.req0_valid = 1'b0;
        look();
        chk("mid_pending", bus.rsp_valid, 1'b1);
        tick();
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        look();
        chk("mid_rst_ready0", bus.req0_ready, 1'b0);
        chk("mid_rst_ready1", bus.req1_ready, 1'b0);
        tick();
        rst = 1'b0;
        look();
        chk("mid_valid", bus.rsp_valid, 1'b0);
        chk("mid_tag", bus.rsp_tag, 4'd0);
        chk("mid_y", bus.rsp_y, 32'd0);
        chk("mid_zero", bus.rsp_zero, 1'b1);
        chk("mid_tie_ready0", bus.req0_ready, 1'b1);
        chk("mid_tie_ready1", bus.req1_ready, 1'b0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // random soak
        soak_on = 1'b1;
        repeat (10000) tick();
        soak_on = 1'b0;
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (4) tick();
        look();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters (req0: integer execute path, req1: address/compare helper) with per-port valid/ready handshakes, round-robin arbitration and a one-entry registered result stage with back-pressure. It sits between the decode/issue logic and the single ALU. Every accepted operation produces exactly one response, tagged with its requester ID and a caller tag.

## Interface
- `TAG_W`, default 4: width of the caller tag passed through with each operation.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on `clk` rising edge.
- `req0_valid` in 1: requester 0 presents an operation.
- `req0_ready` out 1: requester 0 operation accepted this cycle when high with `req0_valid`.
- `req0_a`, `req0_b` in 32: operands.
- `req0_op` in 3: ALU op code.
- `req0_tag` in `TAG_W`: caller tag.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`, `req1_tag`: same as port 0, for requester 1.
- `rsp_valid` out 1: result register holds a result.
- `rsp_ready` in 1: consumer takes the result this cycle.
- `rsp_id` out 1: requester that issued the result (0/1).
- `rsp_tag` out `TAG_W`: tag of that operation.
- `rsp_y` out 32: ALU result.
- `rsp_zero` out 1: `rsp_y == 0`.
- `rsp_ovf` out 1: signed overflow (see Configuration).

## Operation
- Op encoding: 010 add; 110 sub; 000 and; 001 or; 100 a&~b; 101 a|~b; 111 signed set-less-than (result 0/1); 011 undefined, result 0, overflow 0.
- Output stage is free when `!rsp_valid || rsp_ready`.
- Grant (combinational): if the stage is free and exactly one valid, grant it. If both are valid, grant the port not equal to `last` (round-robin). If the stage is not free, grant none.
- `reqN_ready = grant_N`. `ready` never depends on `reqN_valid` of the same port beyond the arbitration itself. A requester must hold its `valid` and operands stable until ready.
- On an accept edge: the muxed operands go to the `alu`. `rsp_y`, `rsp_zero`, `rsp_ovf`, `rsp_id`, `rsp_tag` are registered, `rsp_valid` is set to 1, and `last` is set to the granted ID.
- On an edge with `rsp_valid && rsp_ready` and no accept: `rsp_valid` is set to 0. Payload registers hold their values.
- Simultaneous drain and accept: the new result replaces the old one, `rsp_valid` stays 1, and throughput is one op per cycle.
- While `rsp_valid && !rsp_ready`: all `rsp_*` outputs are held stable and both readies are 0.
- Overflow: add is set when the operand signs are equal and differ from the sum sign. Sub is set when the operand signs differ and the result sign differs from `a`. All other ops give 0.

## Timing
- Latency: accept at edge N gives `rsp_valid` visible after edge N, i.e. the result is available one cycle after acceptance.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_tag`=0, `rsp_y`=0, `rsp_zero`=1, `rsp_ovf`=0, `last`=1 (port 0 wins the first tie).
- With `rst` high, `reqN_ready`=0 combinationally.
- Reset mid-operation discards any pending result; no response is issued for it.
- Readies are combinational from `rsp_valid`, `rsp_ready`, the valids and `last`. There is no combinational path from operands to ready.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break as above.
- `ALU_ARB_RR_EN` undefined: fixed priority, port 0 always wins ties. `last` is not implemented, and port 1 can starve under continuous port-0 traffic.
- All other behaviour is identical in both builds.

## Test plan
- Reset then single op: hold `rst` 2 cycles. Then req0 add a=5 b=7 tag=3 -> `req0_ready`=1 in the same cycle; next cycle `rsp_valid`=1, `rsp_y`=12, `rsp_id`=0, `rsp_tag`=3, `rsp_zero`=0.
- Tie with round-robin: both valid every cycle, `rsp_ready`=1 -> grants alternate 0,1,0,1 starting with 0. In a fixed-priority build, all grants go to 0.
- Back-pressure: `rsp_ready`=0 for 3 cycles with a result held -> both readies 0 and `rsp_*` stable. Raise `rsp_ready` -> a new op is accepted in that same cycle, and `rsp_valid` stays 1 with the new payload.
- Overflow and flags:
  - add 0x7FFFFFFF+1 -> `rsp_ovf`=1.
  - sub 0x80000000-1 -> `rsp_ovf`=1.
  - slt 0xFFFFFFFF<1 -> y=1.
  - sub 9-9 -> y=0, `rsp_zero`=1.
  - op 011 -> y=0.
- Reset mid-flight: result pending with `rsp_ready`=0, assert `rst` 1 cycle -> `rsp_valid`=0 and all outputs at reset values. The next tie goes to port 0.
- Random soak: 10k cycles of random valids, ops and `rsp_ready` -> scoreboard per ID and tag. No lost, duplicated or reordered responses. With round-robin, no port waits more than 1 grant.
